// File: rtl/aes_wrapper.sv
// aes_wrapper: stream-to-block adapter in front of the pipelined AES-128 core.
// Also holds aes_128, the pipelined encryption core it wraps.
//
// aes_wrapper ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   inputData  128-bit word stream; 0 = idle, first non-zero word = key,
//              next word = plaintext
//   out        registered ciphertext of the last completed encryption
// aes_128 ports:
//   clk        rising-edge clock
//   state      plaintext block
//   key        cipher key
//   out        ciphertext, 21 cycles after state/key are applied
//
// state  | meaning
// IDLE   | waiting for a non-zero key word
// GET_PT | capturing the plaintext word, clearing the latency counter
// RUN    | core computing; load out when the counter reaches LATENCY

module aes_128 (
   input  logic         clk,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) plus the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Byte i of the block is bits [127-8i -: 8]; byte i sits at row i%4, column i/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      int src;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
         o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input int r);
      case (r)
         1:       return 8'h01;
         2:       return 8'h02;
         3:       return 8'h04;
         4:       return 8'h08;
         5:       return 8'h10;
         6:       return 8'h20;
         7:       return 8'h40;
         8:       return 8'h80;
         9:       return 8'h1b;
         10:      return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // One stage for the initial AddRoundKey, then two stages per round:
   // SubBytes/ShiftRows alongside key expansion, then MixColumns/AddRoundKey.
   logic [127:0] st [0:10];
   logic [127:0] rk [0:9];
   logic [127:0] sa [1:10];
   logic [127:0] ka [1:10];

   always_ff @(posedge clk) begin
      st[0] <= state ^ key;
      rk[0] <= key;
      for (int r = 1; r <= 10; r++) begin
         sa[r] <= sub_shift(st[r-1]);
         ka[r] <= next_key(rk[r-1], rcon(r));
         st[r] <= ((r == 10) ? sa[r] : mix_cols(sa[r])) ^ ka[r];
      end
      for (int r = 1; r <= 9; r++) begin
         rk[r] <= ka[r];
      end
   end

   assign out = st[10];
endmodule

module aes_wrapper #(
   parameter int LATENCY = 21
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] inputData,
   output logic [127:0] out
);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LAT_TC = CW'(LATENCY);

   typedef enum logic [1:0] {IDLE, GET_PT, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt;
   logic [127:0]  key_r, pt_r, core_out;
   logic          key_ld, pt_ld, cnt_clr, cnt_inc, out_ld;

   aes_128 u_core (
      .clk   (clk),
      .state (pt_r),
      .key   (key_r),
      .out   (core_out)
   );

   always_comb begin
      state_d = state_q;
      key_ld  = 1'b0;
      pt_ld   = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      out_ld  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inputData != '0) begin
               key_ld  = 1'b1;
               state_d = GET_PT;
            end
         end
         GET_PT: begin
            pt_ld   = 1'b1;
            cnt_clr = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (cnt == LAT_TC) begin
               out_ld  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt     <= '0;
         key_r   <= '0;
         pt_r    <= '0;
         out     <= '0;
      end else begin
         state_q <= state_d;
         if (key_ld)  key_r <= inputData;
         if (pt_ld)   pt_r  <= inputData;
         if (cnt_clr) cnt   <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (out_ld)  out   <= core_out;
      end
   end
endmodule

// File: tb/tb_aes_wrapper.sv
module tb_aes_wrapper;
   localparam int LATENCY = 21;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] inputData = '0;
   logic [127:0] out;

   always #5 clk = ~clk;

   aes_wrapper #(.LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inputData (inputData),
      .out       (out)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic [127:0] val;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_errors = 0;
   bit           done = 1'b0;
   logic [7:0]   sbox_tab [0:255];
   logic [127:0] exp_out = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, expv);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table built by walking the multiplicative group with generator 3.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'b0000};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_tab[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] w [0:43][0:3];
      logic [7:0] s [0:3][0:3];
      logic [7:0] t [0:3][0:3];
      logic [7:0] tmp [0:3];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            w[i][j] = key[127-8*(4*i+j) -: 8];
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
         if (i % 4 == 0) begin
            tmp[0] = sbox_tab[w[i-1][1]] ^ rc;
            tmp[1] = sbox_tab[w[i-1][2]];
            tmp[2] = sbox_tab[w[i-1][3]];
            tmp[3] = sbox_tab[w[i-1][0]];
            rc = mul2(rc);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][r];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_tab[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
               s[0][c] = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               s[1][c] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               s[2][c] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               s[3][c] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ w[4*rnd+c][r];
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] rand_nz();
      logic [127:0] v;
      do v = rand128(); while (v == '0);
      return v;
   endfunction

   task automatic drive(input logic [127:0] word);
      @(negedge clk);
      inputData = word;
   endtask

   task automatic idle(input int n);
      repeat (n) drive('0);
   endtask

   // Key sampled at the edge after this negedge (E0); result visible at the
   // negedge following E0 + LATENCY + 2.
   task automatic txn(input logic [127:0] key, input logic [127:0] pt,
                      input logic [127:0] expv, input bit noisy);
      drive(key);
      sb.push_back('{cyc + LATENCY + 3, expv});
      drive(pt);
      repeat (LATENCY + 1) drive(noisy ? rand_nz() : 128'h0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      while (!done) begin
         @(negedge clk);
         if (!done) begin
            if (!rst_n) begin
               exp_out = '0;
               sb.delete();
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
               exp_out = sb[0].val;
               void'(sb.pop_front());
            end
            check("out", out, exp_out);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] k, p;
      build_sbox();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      idle(10);

      txn(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
          128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
      idle(4);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", out, 128'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(2);

      txn(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
      idle(1);

      k = 128'hcb956176982812716aa581a54a532e1d;
      p = 128'hf2b0e56b9af41b8ab6b404325339252f;
      txn(k, p, aes_ref(k, p), 1'b1);
      idle(2);

      k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      txn(k, 128'h0, aes_ref(k, 128'h0), 1'b1);
      k = rand_nz();
      p = rand128();
      txn(k, p, aes_ref(k, p), 1'b0);
      idle(2);

      k = rand_nz();
      p = rand128();
      drive(k);
      sb.push_back('{cyc + LATENCY + 3, aes_ref(k, p)});
      drive(p);
      repeat (10) drive(rand_nz());
      @(posedge clk);
      #2 rst_n = 1'b0;
      inputData = '0;
      #1 check("abort_reset", out, 128'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(25);
      k = rand_nz();
      p = rand128();
      txn(k, p, aes_ref(k, p), 1'b1);

      for (int i = 0; i < 8; i++) begin
         k = rand_nz();
         p = ($urandom_range(0, 3) == 0) ? 128'h0 : rand128();
         txn(k, p, aes_ref(k, p), 1'($urandom_range(0, 1)));
         idle(int'($urandom_range(0, 2)));
      end
      idle(4);

      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
      end
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
